// File: rtl/frl_checkpoint_ctrl_pkg.sv
// Shared types and sizing for the free-register-list checkpoint controller.
package frl_checkpoint_ctrl_pkg;

    localparam int unsigned NUM_D_REG    = 32;
    localparam int unsigned NUM_S_REG    = 16;
    localparam int unsigned FRL_NUM_CKPT = 4;
    localparam int unsigned D_AW         = $clog2(NUM_D_REG);
    localparam int unsigned S_AW         = $clog2(NUM_S_REG);

    typedef struct packed {
        logic                 valid;
        logic [NUM_D_REG-1:0] r_snap;
        logic [NUM_S_REG-1:0] s_snap;
    } frl_ckpt_entry_t;

    typedef enum logic {
        RS_IDLE,
        RS_PULSE
    } rs_state_e;

endpackage

// File: rtl/frl_checkpoint_ctrl_if.sv
// Dispatch / commit / resolve / restore signals of the checkpoint controller.
interface frl_checkpoint_ctrl_if
    import frl_checkpoint_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CKPT = FRL_NUM_CKPT
);
    logic                        take_valid;
    logic                        take_ready;
    logic [$clog2(NUM_CKPT)-1:0] take_id;
    logic [NUM_D_REG-1:0]        cur_r_free;
    logic [NUM_S_REG-1:0]        cur_s_free;
    logic                        return_r;
    logic                        return_s;
    logic [D_AW-1:0]             r_addr;
    logic [S_AW-1:0]             s_addr;
    logic                        resolve_valid;
    logic [$clog2(NUM_CKPT)-1:0] resolve_id;
    logic                        resolve_mispredict;
    logic                        restore;
    logic [NUM_D_REG-1:0]        restore_r_free;
    logic [NUM_S_REG-1:0]        restore_s_free;
    logic                        full;

    // Requester side: dispatch, commit and branch-resolution paths.
    modport master (
        output take_valid, cur_r_free, cur_s_free, return_r, return_s, r_addr, s_addr,
               resolve_valid, resolve_id, resolve_mispredict,
        input  take_ready, take_id, restore, restore_r_free, restore_s_free, full
    );

    // Controller side.
    modport slave (
        input  take_valid, cur_r_free, cur_s_free, return_r, return_s, r_addr, s_addr,
               resolve_valid, resolve_id, resolve_mispredict,
        output take_ready, take_id, restore, restore_r_free, restore_s_free, full
    );
endinterface

// File: rtl/frl_ckpt_slot.sv
// One checkpoint slot: snapshot storage kept coherent with commit returns.
module frl_ckpt_slot
    import frl_checkpoint_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [NUM_D_REG-1:0] load_r_i,
    input  logic [NUM_S_REG-1:0] load_s_i,
    input  logic [NUM_D_REG-1:0] r_mask_i,
    input  logic [NUM_S_REG-1:0] s_mask_i,
    input  logic                 inval_i,
    output frl_ckpt_entry_t      entry_o
);
    frl_ckpt_entry_t entry_q, entry_d;

    // Next slot contents: returns on a live slot, then load, then invalidate.
    always_comb begin
        entry_d = entry_q;
        if (entry_q.valid) begin
            entry_d.r_snap = entry_q.r_snap | r_mask_i;
            entry_d.s_snap = entry_q.s_snap | s_mask_i;
        end
        if (load_i) begin
            entry_d.valid  = 1'b1;
            entry_d.r_snap = load_r_i | r_mask_i;
            entry_d.s_snap = load_s_i | s_mask_i;
        end
        if (inval_i) begin
            entry_d.valid = 1'b0;
        end
    end

    // Slot storage register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;
endmodule

// File: rtl/frl_checkpoint_ctrl.sv
// Checkpoint controller: circular queue of free-list snapshots, one per branch.
module frl_checkpoint_ctrl
    import frl_checkpoint_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CKPT = FRL_NUM_CKPT
)(
    input logic                  clk,
    input logic                  rst,
    frl_checkpoint_ctrl_if.slave bus
);
    localparam int unsigned PW = $clog2(NUM_CKPT);

    logic [PW:0]          head_q, head_d, tail_q, tail_d, occ;
    logic [PW-1:0]        age_r, age_i;
    rs_state_e            rs_q, rs_d;
    logic [NUM_D_REG-1:0] rr_q, rr_d, r_mask;
    logic [NUM_S_REG-1:0] rs_free_q, rs_free_d, s_mask;
    logic [NUM_CKPT-1:0]  load, inval;
    frl_ckpt_entry_t      ent [NUM_CKPT];
    logic                 full, res_hit, mis_fire, cor_fire, take_fire;

    assign occ       = tail_q - head_q;
    assign full      = (occ == (PW+1)'(NUM_CKPT));
    assign r_mask    = bus.return_r ? (NUM_D_REG'(1) << bus.r_addr) : '0;
    assign s_mask    = bus.return_s ? (NUM_S_REG'(1) << bus.s_addr) : '0;
    assign res_hit   = bus.resolve_valid & ent[bus.resolve_id].valid;
    assign mis_fire  = res_hit & bus.resolve_mispredict;
    assign cor_fire  = res_hit & ~bus.resolve_mispredict;
    assign age_r     = bus.resolve_id - head_q[PW-1:0];

    assign bus.take_ready     = ~full & ~(bus.resolve_valid & bus.resolve_mispredict)
                                & (rs_q == RS_IDLE);
    assign bus.take_id        = tail_q[PW-1:0];
    assign bus.full           = full;
    assign bus.restore        = (rs_q == RS_PULSE);
    assign bus.restore_r_free = rr_q;
    assign bus.restore_s_free = rs_free_q;
    assign take_fire          = bus.take_valid & bus.take_ready;

    // Slot load/invalidate; a mispredict kills every slot from its age up to the tail,
    // ages measured from head so a full queue is handled without ambiguity.
    always_comb begin
        load  = '0;
        inval = '0;
        age_i = '0;
        for (int unsigned i = 0; i < NUM_CKPT; i++) begin
            age_i    = PW'(i) - head_q[PW-1:0];
            load[i]  = take_fire && (tail_q[PW-1:0] == PW'(i));
            inval[i] = (cor_fire && (bus.resolve_id == PW'(i)))
                     || (mis_fire && (age_i >= age_r) && ({1'b0, age_i} < occ));
        end
    end

    for (genvar g = 0; g < NUM_CKPT; g++) begin : g_slot
        frl_ckpt_slot u_slot (
            .clk      (clk),
            .rst      (rst),
            .load_i   (load[g]),
            .load_r_i (bus.cur_r_free),
            .load_s_i (bus.cur_s_free),
            .r_mask_i (r_mask),
            .s_mask_i (s_mask),
            .inval_i  (inval[g]),
            .entry_o  (ent[g])
        );
    end

    // Pointer, restore-pulse and restore-data next state.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        rs_d      = mis_fire ? RS_PULSE : RS_IDLE;
        rr_d      = rr_q;
        rs_free_d = rs_free_q;
        if (!ent[head_q[PW-1:0]].valid && (head_q != tail_q)) begin
            head_d = head_q + 1'b1;
        end
        if (mis_fire) begin
            tail_d    = head_q + {1'b0, age_r};
            rr_d      = ent[bus.resolve_id].r_snap | r_mask;
            rs_free_d = ent[bus.resolve_id].s_snap | s_mask;
        end else if (take_fire) begin
            tail_d = tail_q + 1'b1;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            rs_q      <= RS_IDLE;
            rr_q      <= '1;
            rs_free_q <= '1;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            rs_q      <= rs_d;
            rr_q      <= rr_d;
            rs_free_q <= rs_free_d;
        end
    end
endmodule

// File: tb/tb_frl_checkpoint_ctrl.sv
// Directed bench for frl_checkpoint_ctrl.
module tb_frl_checkpoint_ctrl;
    import frl_checkpoint_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int unsigned n_vec, n_bad;

    frl_checkpoint_ctrl_if #(.NUM_CKPT(4)) bus ();

    frl_checkpoint_ctrl #(.NUM_CKPT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.take_valid         = 1'b0;
        bus.cur_r_free         = '0;
        bus.cur_s_free         = '0;
        bus.return_r           = 1'b0;
        bus.return_s           = 1'b0;
        bus.r_addr             = '0;
        bus.s_addr             = '0;
        bus.resolve_valid      = 1'b0;
        bus.resolve_id         = '0;
        bus.resolve_mispredict = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic take(input logic [31:0] r, input logic [15:0] s);
        bus.take_valid = 1'b1;
        bus.cur_r_free = r;
        bus.cur_s_free = s;
    endtask

    task automatic resolve(input logic [1:0] id, input logic mis);
        bus.resolve_valid      = 1'b1;
        bus.resolve_id         = id;
        bus.resolve_mispredict = mis;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rp;
        n_vec = 0;
        n_bad = 0;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_restore", 32'(bus.restore), 32'h0);
        chk("rst_r_free", bus.restore_r_free, 32'hFFFF_FFFF);
        chk("rst_s_free", 32'(bus.restore_s_free), 32'h0000_FFFF);
        chk("rst_full", 32'(bus.full), 32'h0);
        chk("rst_ready", 32'(bus.take_ready), 32'h1);
        chk("rst_id", 32'(bus.take_id), 32'h0);

        // Fill all four slots
        for (int k = 0; k < 4; k++) begin
            rp = 32'hFFFF_FFFF << (4 * (k + 1));
            take(rp, 16'hA000 | 16'(k));
            #1;
            chk("fill_id", 32'(bus.take_id), 32'(k));
            chk("fill_ready", 32'(bus.take_ready), 32'h1);
            tick();
        end
        take(32'h1234_5678, 16'h1234);
        #1;
        chk("full_set", 32'(bus.full), 32'h1);
        chk("full_ready", 32'(bus.take_ready), 32'h0);
        chk("full_id", 32'(bus.take_id), 32'h0);
        tick();
        idle();
        #1;
        chk("fifth_ignored_full", 32'(bus.full), 32'h1);

        // Mispredict slot 2, then the older slot 1 on the next cycle
        resolve(2'd2, 1'b1);
        #1;
        chk("mis_ready_low", 32'(bus.take_ready), 32'h0);
        tick();
        resolve(2'd1, 1'b1);
        #1;
        chk("mis2_restore", 32'(bus.restore), 32'h1);
        chk("mis2_r", bus.restore_r_free, 32'hFFFF_F000);
        chk("mis2_s", 32'(bus.restore_s_free), 32'h0000_A002);
        chk("mis2_ready", 32'(bus.take_ready), 32'h0);
        chk("mis2_full", 32'(bus.full), 32'h0);
        tick();
        idle();
        #1;
        chk("mis1_restore", 32'(bus.restore), 32'h1);
        chk("mis1_r", bus.restore_r_free, 32'hFFFF_FF00);
        chk("mis1_s", 32'(bus.restore_s_free), 32'h0000_A001);
        chk("mis1_id", 32'(bus.take_id), 32'h1);
        tick();
        chk("mis1_pulse_end", 32'(bus.restore), 32'h0);
        chk("mis1_ready_back", 32'(bus.take_ready), 32'h1);

        // Returns folded into the snapshot, including the same-cycle one
        do_reset();
        take(32'hFFFF_FFF0, 16'hFFFF);
        tick();
        idle();
        bus.return_r = 1'b1;
        bus.r_addr   = 5'd2;
        tick();
        bus.r_addr   = 5'd3;
        resolve(2'd0, 1'b1);
        #1;
        chk("ret_ready_low", 32'(bus.take_ready), 32'h0);
        tick();
        idle();
        #1;
        chk("ret_restore", 32'(bus.restore), 32'h1);
        chk("ret_r", bus.restore_r_free, 32'hFFFF_FFFC);
        chk("ret_ready_n1", 32'(bus.take_ready), 32'h0);
        chk("ret_id", 32'(bus.take_id), 32'h0);
        tick();
        chk("ret_pulse_end", 32'(bus.restore), 32'h0);
        chk("ret_ready_n2", 32'(bus.take_ready), 32'h1);

        // Mispredict middle slot of a full queue
        do_reset();
        for (int k = 0; k < 4; k++) begin
            take(32'h1000_0000 + 32'(k), 16'h0);
            tick();
        end
        idle();
        resolve(2'd1, 1'b1);
        tick();
        idle();
        #1;
        chk("mid_r", bus.restore_r_free, 32'h1000_0001);
        tick();
        chk("mid_id", 32'(bus.take_id), 32'h1);
        chk("mid_full", 32'(bus.full), 32'h0);
        for (int k = 1; k < 4; k++) begin
            take(32'h2000_0000, 16'h0);
            #1;
            chk("refill_id", 32'(bus.take_id), 32'(k));
            tick();
        end
        idle();
        #1;
        chk("refill_full", 32'(bus.full), 32'h1);

        // Out-of-order correct resolves: head waits for slot 0
        resolve(2'd1, 1'b0);
        tick();
        idle();
        #1;
        chk("cor1_full", 32'(bus.full), 32'h1);
        resolve(2'd0, 1'b0);
        tick();
        idle();
        #1;
        chk("cor0_full_same", 32'(bus.full), 32'h1);
        tick();
        chk("head_adv_full", 32'(bus.full), 32'h0);
        tick();
        resolve(2'd1, 1'b1);
        tick();
        idle();
        #1;
        chk("stale_mis_ignored", 32'(bus.restore), 32'h0);
        take(32'h3000_0000, 16'h0);
        #1;
        chk("after_head_id0", 32'(bus.take_id), 32'h0);
        chk("after_head_rdy0", 32'(bus.take_ready), 32'h1);
        tick();
        #1;
        chk("after_head_id1", 32'(bus.take_id), 32'h1);
        chk("after_head_rdy1", 32'(bus.take_ready), 32'h1);
        tick();
        idle();
        #1;
        chk("after_head_full", 32'(bus.full), 32'h1);

        // Take colliding with a mispredict is dropped
        do_reset();
        take(32'h5555_0000, 16'h0);
        tick();
        take(32'h0, 16'h0);
        resolve(2'd0, 1'b1);
        #1;
        chk("col_ready_n", 32'(bus.take_ready), 32'h0);
        tick();
        bus.resolve_valid = 1'b0;
        #1;
        chk("col_restore", 32'(bus.restore), 32'h1);
        chk("col_ready_n1", 32'(bus.take_ready), 32'h0);
        chk("col_r", bus.restore_r_free, 32'h5555_0000);
        tick();
        chk("col_pulse_end", 32'(bus.restore), 32'h0);
        chk("col_id", 32'(bus.take_id), 32'h0);
        idle();

        // Async reset during the restore pulse
        do_reset();
        take(32'h0F0F_0000, 16'h0);
        tick();
        idle();
        resolve(2'd0, 1'b1);
        tick();
        idle();
        #1;
        chk("rr_restore_hi", 32'(bus.restore), 32'h1);
        rst = 1'b1;
        #1;
        chk("rr_restore_lo", 32'(bus.restore), 32'h0);
        chk("rr_r", bus.restore_r_free, 32'hFFFF_FFFF);
        chk("rr_id", 32'(bus.take_id), 32'h0);
        chk("rr_full", 32'(bus.full), 32'h0);
        rst = 1'b0;
        #1;
        resolve(2'd0, 1'b1);
        tick();
        idle();
        #1;
        chk("rr_slots_invalid", 32'(bus.restore), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/frl_checkpoint_ctrl.md
# frl_checkpoint_ctrl

Checkpoint controller for the rename free register lists: allocates a checkpoint slot per dispatched branch, snapshots both free lists (`NUM_D_REG` data, `NUM_S_REG` status) into it, and keeps every live snapshot coherent with commit-time register returns. On branch resolution it retires the slot (correct prediction) or drives a one-cycle restore of the snapshot into the free register list and discards the mispredicted branch's slot and every younger slot. Sits between decode/dispatch, the branch resolution path, the reorder-buffer commit port and the free register list's checkpoint input.

## Interface
- NUM_CKPT, 4, number of checkpoint slots (power of two, ≥2)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- take_valid  in  1  branch dispatching this cycle requests a checkpoint
- take_ready  out  1  slot available and no restore pending; take accepted only when both high
- take_id  out  $clog2(NUM_CKPT)  slot id assigned to an accepted take (valid when take_ready)
- cur_r_free  in  NUM_D_REG  free register list data-reg bitvector, next-state value (post this cycle's checkout/return)
- cur_s_free  in  NUM_S_REG  free register list status-reg bitvector, next-state value
- return_r, return_s  in  1 each  commit returning a data / status register
- r_addr  in  $clog2(NUM_D_REG)  returned data register
- s_addr  in  $clog2(NUM_S_REG)  returned status register
- resolve_valid  in  1  branch resolution event
- resolve_id  in  $clog2(NUM_CKPT)  slot of resolving branch
- resolve_mispredict  in  1  1 = mispredict, 0 = correct
- restore  out  1  one-cycle pulse: free register list loads restore_*_free
- restore_r_free  out  NUM_D_REG  data-reg snapshot being restored
- restore_s_free  out  NUM_S_REG  status-reg snapshot being restored
- full  out  1  all NUM_CKPT slots occupied

## Operation
- Slots form a circular queue: head = oldest occupied, tail = next to allocate; pointers carry an extra wrap bit; occupancy = tail − head (wrap-aware).
- Per slot: valid bit, r-snapshot, s-snapshot.
- take_ready = ~full & ~(resolve_valid & resolve_mispredict) & ~restore.
- Accepted take: slot[tail] ← {valid=1, cur_r_free, cur_s_free}; tail += 1; take_id = tail (low bits).
- Commit return (every cycle, independent of take/resolve): for each valid slot, set r-snapshot[r_addr] when return_r, s-snapshot[s_addr] when return_s. A slot written by a take in the same cycle already reflects that return via cur_*_free; the return is also applied to it (idempotent).
- Correct resolve: valid[resolve_id] ← 0. Head advances by one per cycle while valid[head]=0 and head≠tail.
- Mispredict resolve: restore_*_free ← slot[resolve_id] snapshot with the same-cycle commit return applied; restore ← 1 next cycle; valid ← 0 for resolve_id and all slots from resolve_id to tail−1; tail ← resolve_id (wrap bit chosen so occupancy stays consistent with head).
- Resolve naming an invalid slot: ignored, no state change.
- Simultaneous take and mispredict: take not accepted (take_ready low); mispredict proceeds.
- Simultaneous correct resolve and take: both take effect.
- Returns arriving during the restore-pulse cycle: the free register list applies them itself; the controller applies them to surviving slots as usual.

## Timing
- Reset: all valid=0, head=tail=0, restore=0, restore_r_free all 1s, restore_s_free all 1s, full=0, take_ready=1, take_id=0.
- take_ready, take_id, full are combinational from registered state plus resolve inputs.
- Take → slot visible to resolve/returns next cycle.
- Mispredict at cycle N → restore high for cycle N+1 only, outputs stable that cycle; take_ready low in N and N+1; new takes accepted from N+2.
- Back-to-back mispredicts: second mispredict at N+1 is dropped; its slot was already discarded or is older (an older-slot mispredict at N+1 is accepted and produces restore at N+2).
- Full deasserts the cycle after head advances.
- Async rst mid-operation: all state returns to reset values immediately; any in-flight restore pulse is cancelled.

## Structure
- Widths from `NUM_D_REG` / `NUM_S_REG` in nand_cpu.svh; add `NUM_CKPT` there.
- Add a `frl_ckpt_entry_t` struct (valid, r_snap, s_snap) to the shared package.
- One sub-module, `frl_ckpt_slot`: a single slot's storage with load, return-apply and invalidate ports; instantiated NUM_CKPT times.

## Test plan
- Reset, 4 takes with cur_r_free=0xFFFF_FFF0, …0xFFFF_FF00 → take_id 0,1,2,3, full=1, take_ready=0; fifth take ignored.
- Take slot 0, return_r r_addr=2, then mispredict id 0 → restore pulse 1 cycle later, restore_r_free bit 2 set, tail=0.
- Slots 0–3 live, mispredict id 1 → slots 1–3 invalid, occupancy 1, next take_id=1.
- Correct resolve id 1 then id 0 → head stays until id 0 resolves, then advances past 0 and 1 in 2 cycles; full clears.
- Same-cycle take + mispredict id 0 → take dropped, restore next cycle, take_ready low 2 cycles.
- Assert rst during restore cycle → restore drops immediately, all slots invalid, take_id=0.
